// File: rtl/dsp_pkg.sv
// Shared types and constants for the PRI/CPI sample framer.
// Holds the FSM state type, default geometry and the layout of a buffered output beat.
package dsp_pkg;

    localparam int unsigned N_SMP_DEF      = 4096;
    localparam int unsigned N_PRI_DEF      = 32;
    localparam int unsigned FIFO_DEPTH_DEF = 16;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned USER_W = 2;
    localparam int unsigned PRI_W  = 8;
    localparam int unsigned SMP_W  = 13;

    localparam int unsigned TUSER_PRI_BIT = 0;
    localparam int unsigned TUSER_CPI_BIT = 1;

    typedef enum logic [2:0] {
        StIdle,
        StWaitPri,
        StWaitGate,
        StCapture,
        StPriEnd
    } state_e;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
        logic [USER_W-1:0] user;
        logic [PRI_W-1:0]  pri;
        logic [SMP_W-1:0]  smp;
    } beat_t;

    localparam int unsigned BEAT_W = $bits(beat_t);

    function automatic beat_t make_beat(logic [DATA_W-1:0] data, logic last,
                                        logic [PRI_W-1:0] pri, logic [SMP_W-1:0] smp);
        beat_t b;
        b                     = '0;
        b.data                = data;
        b.last                = last;
        b.user[TUSER_PRI_BIT] = (smp == '0);
        b.user[TUSER_CPI_BIT] = (smp == '0) && (pri == '0);
        b.pri                 = pri;
        b.smp                 = smp;
        return b;
    endfunction

endpackage

// File: rtl/dsp_pri_framer_if.sv
// Framed output stream of the PRI framer: AXI-Stream style beat plus sideband indices.
// The framer drives through the master modport; the consumer uses the slave modport.
interface dsp_pri_framer_if;
    import dsp_pkg::*;

    logic              o_tvalid;
    logic [DATA_W-1:0] o_tdata;
    logic              o_tlast;
    logic [USER_W-1:0] o_tuser;
    logic [PRI_W-1:0]  o_pri_idx;
    logic [SMP_W-1:0]  o_smp_idx;
    logic              i_tready;

    modport master (
        output o_tvalid, o_tdata, o_tlast, o_tuser, o_pri_idx, o_smp_idx,
        input  i_tready
    );

    modport slave (
        input  o_tvalid, o_tdata, o_tlast, o_tuser, o_pri_idx, o_smp_idx,
        output i_tready
    );

endinterface

// File: rtl/dsp_sfifo.sv
// Synchronous FIFO with a show-ahead read port; a write into a full FIFO is dropped
// and flagged, unless a read in the same cycle frees the slot. DEPTH is a power of 2, >= 2.
module dsp_sfifo #(
    parameter int unsigned WIDTH = 40,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             drop,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    input  logic             rd_ready
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             full;
    logic             pop;
    logic             wr_ok;

    assign full     = (count == (AW+1)'(DEPTH));
    assign rd_valid = (count != '0);
    assign pop      = rd_valid & rd_ready;
    assign wr_ok    = wr_en & (~full | pop);
    assign drop     = wr_en & full & ~pop;
    // Force the data lines low while empty so the stream reads all-zero after reset.
    assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/dsp_pri_framer.sv
// Frames a free-running ADC sample stream into PRIs and CPIs using marker inputs,
// tags each sample with indices and first/last flags, and buffers it for the consumer.
module dsp_pri_framer
    import dsp_pkg::*;
#(
    parameter int unsigned N_SMP      = N_SMP_DEF,
    parameter int unsigned N_PRI      = N_PRI_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_cpib,
    input  logic              i_cpie,
    input  logic              i_pri,
    input  logic              i_smp_gate,
    input  logic              i_tvalid,
    input  logic [DATA_W-1:0] i_tdata,
    dsp_pri_framer_if.master  m_axis,
    output logic              o_cpi_done,
    output logic              o_err_short,
    output logic              o_err_ovf,
    output logic              o_err_resync
);

    localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(N_SMP - 1);
    localparam logic [PRI_W-1:0] PRI_LAST = PRI_W'(N_PRI - 1);

    state_e            state;
    logic              cpib_d, cpie_d, pri_d, gate_d;
    logic              cpib_e, cpie_e, pri_e, gate_e;
    logic [PRI_W-1:0]  pri_idx;
    logic [SMP_W-1:0]  smp_cnt;
    logic              cpie_seen;
    logic              push_vld;
    beat_t             push_beat;
    logic              drop;
    logic              fifo_valid;
    logic [BEAT_W-1:0] pop_vec;
    beat_t             pop_beat;

    assign cpib_e = i_cpib & ~cpib_d;
    assign cpie_e = i_cpie & ~cpie_d;
    assign pri_e  = i_pri & ~pri_d;
    assign gate_e = i_smp_gate & ~gate_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= StIdle;
            cpib_d       <= 1'b0;
            cpie_d       <= 1'b0;
            pri_d        <= 1'b0;
            gate_d       <= 1'b0;
            pri_idx      <= '0;
            smp_cnt      <= '0;
            cpie_seen    <= 1'b0;
            push_vld     <= 1'b0;
            push_beat    <= '0;
            o_cpi_done   <= 1'b0;
            o_err_short  <= 1'b0;
            o_err_ovf    <= 1'b0;
            o_err_resync <= 1'b0;
        end else begin
            cpib_d       <= i_cpib;
            cpie_d       <= i_cpie;
            pri_d        <= i_pri;
            gate_d       <= i_smp_gate;
            push_vld     <= 1'b0;
            o_cpi_done   <= 1'b0;
            o_err_short  <= 1'b0;
            o_err_resync <= 1'b0;
            o_err_ovf    <= drop;

            // A new CPI start while framing restarts the CPI; buffered beats stay queued.
            if (state != StIdle && cpib_e) begin
                o_err_resync <= 1'b1;
                pri_idx      <= '0;
                smp_cnt      <= '0;
                cpie_seen    <= 1'b0;
                state        <= StWaitPri;
            end else begin
                if (state != StIdle && cpie_e) cpie_seen <= 1'b1;
                unique case (state)
                    StIdle: begin
                        if (cpib_e) begin
                            pri_idx   <= '0;
                            cpie_seen <= 1'b0;
                            state     <= StWaitPri;
                        end
                    end
                    StWaitPri: begin
                        if (pri_e) state <= StWaitGate;
                    end
                    StWaitGate: begin
                        if (gate_e) begin
                            smp_cnt <= '0;
                            state   <= StCapture;
                            if (i_tvalid) begin
                                push_vld  <= 1'b1;
                                push_beat <= make_beat(i_tdata, 1'b0, pri_idx, '0);
                                smp_cnt   <= SMP_W'(1);
                            end
                        end
                    end
                    StCapture: begin
                        if (!i_smp_gate) begin
                            o_err_short <= 1'b1;
                            state       <= StPriEnd;
                        end else if (i_tvalid) begin
                            push_vld  <= 1'b1;
                            push_beat <= make_beat(i_tdata, smp_cnt == SMP_LAST, pri_idx, smp_cnt);
                            if (smp_cnt == SMP_LAST) state <= StPriEnd;
                            else                     smp_cnt <= smp_cnt + 1'b1;
                        end
                    end
                    StPriEnd: begin
                        if (pri_idx == PRI_LAST || cpie_seen) begin
                            o_cpi_done <= 1'b1;
                            state      <= StIdle;
                        end else begin
                            pri_idx <= pri_idx + 1'b1;
                            state   <= StWaitPri;
                        end
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

    dsp_sfifo #(
        .WIDTH (BEAT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (push_vld),
        .wr_data  (push_beat),
        .drop     (drop),
        .rd_valid (fifo_valid),
        .rd_data  (pop_vec),
        .rd_ready (m_axis.i_tready)
    );

    assign pop_beat         = beat_t'(pop_vec);
    assign m_axis.o_tvalid  = fifo_valid;
    assign m_axis.o_tdata   = pop_beat.data;
    assign m_axis.o_tlast   = pop_beat.last;
    assign m_axis.o_tuser   = pop_beat.user;
    assign m_axis.o_pri_idx = pop_beat.pri;
    assign m_axis.o_smp_idx = pop_beat.smp;

endmodule

// File: tb/tb_dsp_pri_framer.sv
// Self-checking bench for dsp_pri_framer: scenario table of CPIs with random data,
// spacing and backpressure, plus directed latency, resync, reset and overflow sequences.
module tb_dsp_pri_framer;
    import dsp_pkg::*;

    localparam int unsigned N_SMP = 256;
    localparam int unsigned N_PRI = 4;
    localparam int unsigned DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst, cpib, cpie, pri, gate, tvalid;
    logic [15:0] tdata;
    logic        done, short_p, ovf, resync;

    dsp_pri_framer_if axis ();

    dsp_pri_framer #(
        .N_SMP      (N_SMP),
        .N_PRI      (N_PRI),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_cpib       (cpib),
        .i_cpie       (cpie),
        .i_pri        (pri),
        .i_smp_gate   (gate),
        .i_tvalid     (tvalid),
        .i_tdata      (tdata),
        .m_axis       (axis),
        .o_cpi_done   (done),
        .o_err_short  (short_p),
        .o_err_ovf    (ovf),
        .o_err_resync (resync)
    );

    always #5 clk = ~clk;

    typedef struct {
        int n_pri;      // PRIs driven inside the CPI
        int short_at;   // PRI cut short by an early gate fall, -1 for none
        int short_len;
        int cpie_at;    // PRI during which the CPI-end marker rises, -1 for none
        int ghost;      // extra PRIs driven after the CPI should have closed
        int exp_done;
        int exp_short;
        int exp_last;
        int exp_maxpri;
        int exp_first;  // beats flagged as first of CPI
    } vec_t;

    vec_t  vecs[6];
    beat_t exp_q[$];
    int    errs = 0, checks = 0;
    int    n_done = 0, n_short = 0, n_ovf = 0, n_resync = 0;
    int    n_last = 0, n_first = 0, n_beats = 0, max_pri = 0;
    bit    rand_rdy = 1'b0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        beat_t act, e;
        act = '{data: axis.o_tdata, last: axis.o_tlast, user: axis.o_tuser,
                pri: axis.o_pri_idx, smp: axis.o_smp_idx};
        if (axis.o_tvalid && axis.i_tready) begin
            n_beats++;
            if (act.last) n_last++;
            if (act.user == 2'b11) n_first++;
            if (int'(act.pri) > max_pri) max_pri = int'(act.pri);
            if (exp_q.size() == 0) begin
                checks++;
                errs++;
                $display("FAIL unexpected_beat: got %0h expected none", act);
            end else begin
                e = exp_q.pop_front();
                check("beat", 64'(act), 64'(e));
            end
        end
        n_done   += int'(done);
        n_short  += int'(short_p);
        n_ovf    += int'(ovf);
        n_resync += int'(resync);
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        if (rand_rdy) axis.i_tready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic push_exp(logic [15:0] d, bit last, int p, int s);
        beat_t b;
        b.data = d;
        b.last = last;
        b.user = {(s == 0) && (p == 0), s == 0};
        b.pri  = 8'(p);
        b.smp  = 13'(s);
        exp_q.push_back(b);
    endtask

    task automatic start_cpi();
        cpib = 1'b1;
        repeat (3) tick();
        cpib = 1'b0;
        tick();
    endtask

    task automatic pri_edge();
        pri = 1'b1;
        tick();
        tick();
        pri = 1'b0;
        tick();
    endtask

    // One PRI: marker, gate rising together with the first sample, n randomly spaced samples.
    task automatic drive_pri(int n, bit full, int cpie_smp, bit expect_out, int pidx);
        pri_edge();
        gate = 1'b1;
        for (int j = 0; j < n; j++) begin
            tvalid = 1'b1;
            tdata  = 16'($urandom);
            if (expect_out) push_exp(tdata, full && (j == N_SMP - 1), pidx, j);
            if (j == cpie_smp) cpie = 1'b1;
            tick();
            tvalid = 1'b0;
            repeat ($urandom_range(1, 3)) tick();
        end
        gate = 1'b0;
        cpie = 1'b0;
        repeat (3) tick();
    endtask

    task automatic drain();
        int guard;
        rand_rdy       = 1'b0;
        axis.i_tready  = 1'b1;
        guard          = 0;
        while (exp_q.size() != 0 && guard < 300) begin
            tick();
            guard++;
        end
        repeat (4) tick();
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic all_outputs_zero(string name);
        check(name, {axis.o_tvalid, axis.o_tdata, axis.o_tlast, axis.o_tuser, axis.o_pri_idx,
                     axis.o_smp_idx, done, short_p, ovf, resync}, 64'd0);
    endtask

    initial begin
        int b_done, b_short, b_ovf, b_res, b_last, b_first, b_beats;

        vecs[0] = '{4, -1, 0,  -1, 0, 1, 0, 4, 3, 1};
        vecs[1] = '{2, -1, 0,   1, 1, 1, 0, 2, 1, 1};
        vecs[2] = '{4,  1, 10, -1, 0, 1, 1, 3, 3, 1};
        vecs[3] = '{4,  3, 5,  -1, 0, 1, 1, 3, 3, 1};
        vecs[4] = '{4, -1, 0,   3, 0, 1, 0, 4, 3, 1};
        vecs[5] = '{1,  0, 7,   0, 1, 1, 1, 0, 0, 1};

        rst = 1'b1; cpib = 1'b0; cpie = 1'b0; pri = 1'b0; gate = 1'b0;
        tvalid = 1'b0; tdata = '0; axis.i_tready = 1'b1;
        repeat (2) tick();
        all_outputs_zero("reset_outputs");
        rst = 1'b0;

        // Markers and samples before any CPI start must produce nothing.
        b_beats = n_beats;
        drive_pri(20, 1'b0, -1, 1'b0, 0);
        check("no_output_before_cpib", 64'(n_beats - b_beats), 64'd0);

        // Latency: sample accepted on the gate edge, visible two cycles later.
        start_cpi();
        pri_edge();
        gate = 1'b1; tvalid = 1'b1; tdata = 16'hA5C3;
        push_exp(tdata, 1'b0, 0, 0);
        tick();
        check("latency_cycle1_tvalid", 64'(axis.o_tvalid), 64'd0);
        tvalid = 1'b0;
        tick();
        check("latency_cycle2_tvalid", 64'(axis.o_tvalid), 64'd1);
        check("latency_first_tuser", 64'(axis.o_tuser), 64'd3);
        for (int j = 1; j < 5; j++) begin
            tvalid = 1'b1; tdata = 16'($urandom);
            push_exp(tdata, 1'b0, 0, j);
            tick();
        end
        tvalid = 1'b0;

        // Resync: new CPI begin while capturing.
        b_res = n_resync; b_short = n_short;
        cpib = 1'b1;
        tick();
        cpib = 1'b0; gate = 1'b0;
        repeat (3) tick();
        check("resync_pulse", 64'(n_resync - b_res), 64'd1);
        check("resync_no_short", 64'(n_short - b_short), 64'd0);
        pri_edge();
        gate = 1'b1; tvalid = 1'b1; tdata = 16'($urandom);
        push_exp(tdata, 1'b0, 0, 0);
        tick();
        axis.i_tready = 1'b0;
        for (int j = 1; j < 6; j++) begin
            tdata = 16'($urandom);
            tick();
        end
        tvalid = 1'b0;
        check("held_tvalid_before_reset", 64'(axis.o_tvalid), 64'd1);

        // Asynchronous reset mid-capture with buffered beats.
        rst = 1'b1;
        #1;
        all_outputs_zero("reset_mid_capture_outputs");
        exp_q.delete();
        tick();
        rst = 1'b0; axis.i_tready = 1'b1; gate = 1'b0;
        b_beats = n_beats;
        drive_pri(10, 1'b0, -1, 1'b0, 0);
        repeat (5) tick();
        check("no_output_after_reset", 64'(n_beats - b_beats), 64'd0);

        // Overflow: 200 back-to-back samples with the consumer stalled.
        b_ovf = n_ovf; b_done = n_done; b_last = n_last; b_short = n_short;
        start_cpi();
        pri_edge();
        axis.i_tready = 1'b0;
        gate = 1'b1;
        for (int j = 0; j < 200; j++) begin
            tvalid = 1'b1; tdata = 16'($urandom);
            if (j < int'(DEPTH)) push_exp(tdata, 1'b0, 0, j);
            tick();
        end
        tvalid = 1'b0;
        repeat (3) tick();
        axis.i_tready = 1'b1;
        for (int j = 200; j < int'(N_SMP); j++) begin
            tvalid = 1'b1; tdata = 16'($urandom);
            push_exp(tdata, j == int'(N_SMP) - 1, 0, j);
            if (j == 250) cpie = 1'b1;
            tick();
        end
        tvalid = 1'b0; cpie = 1'b0; gate = 1'b0;
        drain();
        check("ovf_pulses", 64'(n_ovf - b_ovf), 64'd184);
        check("ovf_cpi_done", 64'(n_done - b_done), 64'd1);
        check("ovf_tlast", 64'(n_last - b_last), 64'd1);
        check("ovf_no_short", 64'(n_short - b_short), 64'd0);

        // Scenario table with random data, spacing and backpressure.
        for (int v = 0; v < 6; v++) begin
            b_done = n_done; b_short = n_short; b_ovf = n_ovf; b_res = n_resync;
            b_last = n_last; b_first = n_first;
            max_pri  = 0;
            rand_rdy = 1'b1;
            start_cpi();
            for (int p = 0; p < vecs[v].n_pri; p++) begin
                if (p == vecs[v].short_at)
                    drive_pri(vecs[v].short_len, 1'b0, (p == vecs[v].cpie_at) ? 3 : -1, 1'b1, p);
                else
                    drive_pri(N_SMP, 1'b1, (p == vecs[v].cpie_at) ? 3 : -1, 1'b1, p);
            end
            for (int g = 0; g < vecs[v].ghost; g++) drive_pri(12, 1'b0, -1, 1'b0, 0);
            drain();
            check($sformatf("v%0d_cpi_done", v), 64'(n_done - b_done), 64'(vecs[v].exp_done));
            check($sformatf("v%0d_err_short", v), 64'(n_short - b_short), 64'(vecs[v].exp_short));
            check($sformatf("v%0d_tlast", v), 64'(n_last - b_last), 64'(vecs[v].exp_last));
            check($sformatf("v%0d_max_pri", v), 64'(max_pri), 64'(vecs[v].exp_maxpri));
            check($sformatf("v%0d_cpi_first", v), 64'(n_first - b_first), 64'(vecs[v].exp_first));
            check($sformatf("v%0d_no_ovf", v), 64'(n_ovf - b_ovf), 64'd0);
            check($sformatf("v%0d_no_resync", v), 64'(n_resync - b_res), 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
